// File: rtl/counter_4bit_updown.sv
`default_nettype none
// ============================================================================
// Module      : counter_4bit_updown
// Description : WIDTH-bit up/down binary counter with synchronous parallel
//               load, count enable, combinational terminal-count flag and a
//               registered one-cycle wrap pulse.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous reset, active-high (cn <= RST_VAL, co <= 0)
//               en   - count enable
//               ud   - direction, 1 = up, 0 = down
//               load - synchronous parallel load of cin (highest priority)
//               cin  - parallel load value
//               cn   - registered counter value
//               tc   - terminal count for the current direction (combinational)
//               co   - wrap pulse, high for one cycle after a wrapping edge
// Revision    : 1.0 - initial release
// ============================================================================
module counter_4bit_updown #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] cn,
    output logic             tc,
    output logic             co
);

    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cn;
    logic             r_co;
    logic [WIDTH-1:0] w_cn_step;
    logic             w_tc;

    // Terminal count depends on the direction currently requested, so it is
    // also exactly the condition under which an enabled count would wrap.
    assign w_tc      = ud ? (r_cn == c_all_ones) : (r_cn == c_zero);

    // Unsigned modulo-2^WIDTH step; wrap-around falls out of the truncation.
    assign w_cn_step = ud ? (r_cn + c_one) : (r_cn - c_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cn <= RST_VAL;
            r_co <= 1'b0;
        end else if (load) begin
            r_cn <= cin;
            r_co <= 1'b0;
        end else if (en) begin
            r_cn <= w_cn_step;
            r_co <= w_tc;
        end else begin
            r_co <= 1'b0;
        end
    end

    assign cn = r_cn;
    assign tc = w_tc;
    assign co = r_co;

endmodule
`default_nettype wire

// File: tb/tb_counter_4bit_updown.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_counter_4bit_updown
// Description : Self-checking bench for counter_4bit_updown. Directed steps
//               followed by random stimulus, all compared with an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_4bit_updown;

    localparam int               WIDTH = 4;
    localparam int               MOD   = 1 << WIDTH;
    localparam int               MAXV  = MOD - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             ud;
    logic             load;
    logic [WIDTH-1:0] cin;
    logic [WIDTH-1:0] cn;
    logic             tc;
    logic             co;

    int total;
    int bad;

    // Reference model state
    int m_cn;
    int m_co;

    counter_4bit_updown #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ud   (ud),
        .load (load),
        .cin  (cin),
        .cn   (cn),
        .tc   (tc),
        .co   (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag);
        logic [WIDTH-1:0] e_cn;
        logic             e_co;
        logic             e_tc;
        e_cn = WIDTH'(m_cn);
        e_co = (m_co != 0);
        e_tc = ud ? (m_cn == MAXV) : (m_cn == 0);
        total++;
        assert (cn === e_cn) else begin
            bad++;
            $error("FAIL %s cn observed=%0h expected=%0h", tag, cn, e_cn);
        end
        total++;
        assert (co === e_co) else begin
            bad++;
            $error("FAIL %s co observed=%b expected=%b", tag, co, e_co);
        end
        total++;
        assert (tc === e_tc) else begin
            bad++;
            $error("FAIL %s tc observed=%b expected=%b", tag, tc, e_tc);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge happen, update the
    // model from the same inputs and check 1 ns after the edge.
    task automatic step(input logic i_load, input logic i_en, input logic i_ud,
                        input logic [WIDTH-1:0] i_cin, input string tag);
        @(negedge clk);
        load = i_load;
        en   = i_en;
        ud   = i_ud;
        cin  = i_cin;
        @(posedge clk);
        if (i_load) begin
            m_cn = int'(i_cin);
            m_co = 0;
        end else if (i_en && i_ud) begin
            m_co = (m_cn == MAXV) ? 1 : 0;
            m_cn = (m_cn + 1) % MOD;
        end else if (i_en) begin
            m_co = (m_cn == 0) ? 1 : 0;
            m_cn = (m_cn + MOD - 1) % MOD;
        end else begin
            m_co = 0;
        end
        #1;
        check(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_cn  = 0;
        m_co  = 0;
        rst   = 1'b1;
        en    = 1'b0;
        ud    = 1'b0;
        load  = 1'b0;
        cin   = '0;

        // Reset state, including tc while reset is held
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Async reset between edges from cn=7
        step(1'b1, 1'b0, 1'b1, 4'd7, "load7");
        rst = 1'b1;
        #1;
        m_cn = 0;
        m_co = 0;
        check("async_rst");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 4'd5, "hold_after_rst");

        // Up count through wrap; cin is undriven since load is low
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 'x, "up_count");

        // Load 15 then count down through wrap
        step(1'b1, 1'b0, 1'b0, 4'b1111, "load15");
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 4'd0, "down_count");

        // Load has priority over counting
        step(1'b1, 1'b1, 1'b1, 4'b1010, "load_prio_a");
        step(1'b1, 1'b1, 1'b1, 4'b0011, "load_prio_b");

        // Enable hold then direction changes
        step(1'b1, 1'b0, 1'b1, 4'd6, "load6");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'd0, "en_hold");
        step(1'b0, 1'b1, 1'b1, 4'd0, "dir_up");
        step(1'b0, 1'b1, 1'b0, 4'd0, "dir_down");
        step(1'b0, 1'b1, 1'b1, 4'd0, "dir_up2");

        // Reset mid-count at cn=9, 3 ns pulse between edges
        step(1'b1, 1'b0, 1'b1, 4'd8, "load8");
        step(1'b0, 1'b1, 1'b1, 4'd0, "up_to9");
        rst = 1'b1;
        #1;
        m_cn = 0;
        m_co = 0;
        check("mid_rst");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'd0, "resume");

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                 WIDTH'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
